audio_pwm_out: RTL and testbench
================================

// Module: audio_pwm_out
//
// PURPOSE
//   Output stage directly downstream of the effect chain. Consumes signed effect samples (data/vld strobe).
//   Applies a volume attenuation, converts the sample to offset binary and drives a 1-bit PWM audio output.
//   Each sample is double-buffered and applied on PWM period boundaries, so the duty cycle never changes mid-period.
//   Emits a per-period tick and sticky overrun/underrun flags for the control logic.
//
// PARAMETERS
//   DATA_WIDTH  8  sample width; the PWM period is 2**DATA_WIDTH clk cycles
//
// PORTS
//   clk     in   1           system clock
//   rst     in   1           synchronous, active-high reset
//   en      in   1           0 = mute: midscale is loaded at each boundary instead of the sample
//   vol     in   2           attenuation, arithmetic right shift of the sample by 0..3
//   data_i  in   DATA_WIDTH  signed two's-complement sample
//   vld_i   in   1           one-cycle strobe qualifying data_i; there is no backpressure
//   clr_i   in   1           clears ovr_o and udr_o
//   pwm_o   out  1           registered PWM output
//   tick_o  out  1           one-cycle pulse per PWM period
//   ovr_o   out  1           sticky: a sample was overwritten before it was consumed
//   udr_o   out  1           sticky: a period boundary passed with no new sample
//
// BEHAVIOUR
//   Reset values (registered; take effect at the first edge with rst=1, including mid-operation):
//     cnt=0, duty=MIDSCALE (2**(W-1)), pend=0, pend_vld=0, started=0.
//     pwm_o=0, tick_o=0, ovr_o=0, udr_o=0.
//   Counter
//     - cnt free-runs 0 .. 2**W-1 and wraps.
//     - boundary = (cnt == 2**W-1).
//   Capture
//     - On vld_i: pend <= data_i, pend_vld <= 1, started <= 1.
//     - Conversion is done at load time, not at capture.
//   Load, on boundary:
//     - If pend_vld: duty <= conv(pend) and pend_vld <= 0. This uses the pre-edge pend value.
//     - Else: duty holds its value, and udr_o is set if started=1.
//     - If en=0: duty <= MIDSCALE. pend_vld still clears and the udr rule is unchanged.
//   Conversion
//     - a = pend >>> vol (sign preserved).
//     - conv = {~a[W-1], a[W-2:0]}.
//     - Examples: -128 -> 0, 0 -> 128, 127 -> 255.
//   Simultaneous vld_i and boundary
//     - duty takes the old pend.
//     - The new sample lands in pend with pend_vld=1.
//     - No overrun is flagged.
//   Overrun
//     - vld_i while pend_vld=1 and not boundary: pend is overwritten (newest wins) and ovr_o is set.
//   Sticky flags
//     - clr_i clears ovr_o and udr_o.
//     - If a set event and clr_i occur in the same cycle, set wins.
//   PWM
//     - pwm_o <= (cnt < duty), registered, so pwm_o lags cnt by 1 cycle.
//     - High time per period = duty cycles.
//     - duty=0 gives a constant low output.
//   Tick
//     - tick_o asserts the cycle after boundary, i.e. aligned with cnt==0.
//     - The first tick occurs 2**W cycles after rst deasserts.
//   Latency
//     - A sample is applied at the next boundary: worst case 2**W cycles.
//     - It is then visible on pwm_o 1 cycle later.
//
// STRUCTURE
//   Shared package audio_pkg:
//     - sample_t: logic signed [DATA_WIDTH-1:0]
//     - MIDSCALE constant
//     - function to_offset_bin(sample_t s, logic [1:0] sh)
//   Sub-module pwm_gen (cnt, boundary, compare, registered pwm_o):
//     - reused by other output channels
//     - instantiated once here
//   Top level holds pend/duty, the load logic and the flags.
//
// TESTING (DATA_WIDTH=8)
//   1. Reset release, no input
//      -> pwm_o high 128 of every 256 cycles.
//      -> tick_o every 256 cycles.
//      -> udr_o stays 0 (started=0).
//   2. Samples -128 / 0 / 127 fed one per period, vol=0
//      -> high times 0 / 128 / 255 in the following periods.
//   3. vld_i exactly on cnt==255 with pend_vld=1
//      -> old pend applied next period.
//      -> new sample applied the period after.
//      -> ovr_o=0.
//   4. Two vld_i within one period (values 10, 20)
//      -> ovr_o=1.
//      -> duty=148 (20 wins).
//      -> clr_i then drops ovr_o.
//   5. Feeding stops after one sample
//      -> duty held.
//      -> udr_o=1 at the next boundary.
//      -> en=0 then gives 128 from the next period.
//   6. vol=2 with sample -128
//      -> high time 96.
//   7. rst asserted mid-period
//      -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio output types: sample format, midscale constant and the
// signed-to-offset-binary conversion used by the PWM output channels.
package audio_pkg;

    localparam int unsigned SAMPLE_WIDTH = 8;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    // Attenuate by an arithmetic shift, then flip the sign bit to get offset binary.
    function automatic logic [SAMPLE_WIDTH-1:0] to_offset_bin(sample_t s, logic [1:0] sh);
        sample_t a;
        a = s >>> sh;
        return {~a[SAMPLE_WIDTH-1], a[SAMPLE_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM generator: period counter, boundary detect, registered
// compare output and a per-period tick aligned with cnt == 0.
module pwm_gen #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] duty_i,
    output logic             boundary_o,
    output logic             pwm_o,
    output logic             tick_o
);

    logic [Width-1:0] cnt_q;
    logic             pwm_q;
    logic             tick_q;

    assign boundary_o = (cnt_q == {Width{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pwm_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            pwm_q  <= (cnt_q < duty_i);
            tick_q <= boundary_o;
        end
    end

    assign pwm_o  = pwm_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/audio_pwm_out.sv
// Audio PWM output stage: double-buffers effect samples, applies volume and
// mute at period boundaries, and reports overrun/underrun as sticky flags.
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            vol,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  vld_i,
    input  logic                  clr_i,
    output logic                  pwm_o,
    output logic                  tick_o,
    output logic                  ovr_o,
    output logic                  udr_o
);

    sample_t               pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  started_q, started_d;
    logic [DATA_WIDTH-1:0] duty_q, duty_d;
    logic                  ovr_q, ovr_d;
    logic                  udr_q, udr_d;
    logic                  ovr_set, udr_set;
    logic                  boundary;

    pwm_gen #(
        .Width (DATA_WIDTH)
    ) u_pwm_gen (
        .clk        (clk),
        .rst        (rst),
        .duty_i     (duty_q),
        .boundary_o (boundary),
        .pwm_o      (pwm_o),
        .tick_o     (tick_o)
    );

    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        started_d  = started_q;
        duty_d     = duty_q;
        ovr_set    = 1'b0;
        udr_set    = 1'b0;

        // Load uses the pre-edge pend so a coincident strobe is kept for the next period.
        if (boundary) begin
            if (pend_vld_q) begin
                duty_d     = to_offset_bin(pend_q, vol);
                pend_vld_d = 1'b0;
            end else begin
                udr_set = started_q;
            end
            if (!en) begin
                duty_d = MIDSCALE;
            end
        end

        if (vld_i) begin
            ovr_set    = pend_vld_q && !boundary;
            pend_d     = sample_t'(data_i);
            pend_vld_d = 1'b1;
            started_d  = 1'b1;
        end

        // Set takes priority over a simultaneous clear.
        ovr_d = ovr_set | (ovr_q & ~clr_i);
        udr_d = udr_set | (udr_q & ~clr_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            started_q  <= 1'b0;
            duty_q     <= MIDSCALE;
            ovr_q      <= 1'b0;
            udr_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            started_q  <= started_d;
            duty_q     <= duty_d;
            ovr_q      <= ovr_d;
            udr_q      <= udr_d;
        end
    end

    assign ovr_o = ovr_q;
    assign udr_o = udr_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out: per-period vectors with expected
// high time and flags, plus a hand-written mid-period reset sequence.
module tb_audio_pwm_out;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] vol;
    logic [7:0] data_i;
    logic       vld_i;
    logic       clr_i;
    logic       pwm_o;
    logic       tick_o;
    logic       ovr_o;
    logic       udr_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int vld_at;   // cycle (pre-edge cnt) of first strobe, -1 = none
        int d1;
        int vld2_at;  // cycle of second strobe, -1 = none
        int d2;
        int clr_at;   // cycle of clr_i pulse, -1 = none
        bit en;
        int vol;
        int exp_high;
        bit exp_ovr;
        bit exp_udr;
    } vec_t;

    vec_t vecs[16];
    int   sb_q[$];

    audio_pwm_out #(
        .DATA_WIDTH (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .vol    (vol),
        .data_i (data_i),
        .vld_i  (vld_i),
        .clr_i  (clr_i),
        .pwm_o  (pwm_o),
        .tick_o (tick_o),
        .ovr_o  (ovr_o),
        .udr_o  (udr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Runs exactly one PWM period starting with cnt == 0 pre-edge; the last
    // sample (tick cycle) still reflects this period's cnt == 255 compare.
    task automatic run_period(input int idx, input vec_t v);
        int hi;
        int tick_bad;
        int exp_hi;
        hi       = 0;
        tick_bad = 0;
        sb_q.push_back(v.exp_high);
        en  = v.en;
        vol = 2'(v.vol);
        for (int k = 0; k < 256; k++) begin
            vld_i  = (k == v.vld_at) || (k == v.vld2_at);
            data_i = (k == v.vld2_at) ? 8'(v.d2) : 8'(v.d1);
            clr_i  = (k == v.clr_at);
            @(posedge clk);
            #1;
            hi += int'(pwm_o);
            if (tick_o != (k == 255)) tick_bad++;
        end
        vld_i = 1'b0;
        clr_i = 1'b0;
        exp_hi = sb_q.pop_front();
        check($sformatf("v%0d high_time", idx), hi, exp_hi);
        check($sformatf("v%0d tick_misplaced", idx), tick_bad, 0);
        check($sformatf("v%0d ovr_o", idx), int'(ovr_o), int'(v.exp_ovr));
        check($sformatf("v%0d udr_o", idx), int'(udr_o), int'(v.exp_udr));
    endtask

    initial begin
        vec_t idle;
        // vld_at d1 vld2_at d2 clr_at en vol exp_high exp_ovr exp_udr
        vecs[0]  = '{-1,    0,  -1,  0,  -1, 1, 0, 128, 0, 0}; // idle midscale
        vecs[1]  = '{-1,    0,  -1,  0,  -1, 1, 0, 128, 0, 0}; // no udr before start
        vecs[2]  = '{50, -128,  -1,  0,  -1, 1, 0, 128, 0, 0};
        vecs[3]  = '{50,    0,  -1,  0,  -1, 1, 0,   0, 0, 0}; // -128 -> 0
        vecs[4]  = '{50,  127,  -1,  0,  -1, 1, 0, 128, 0, 0}; // 0 -> 128
        vecs[5]  = '{50,   10, 255, 20,  -1, 1, 0, 255, 0, 0}; // 127 -> 255, vld on boundary
        vecs[6]  = '{-1,    0,  -1,  0,  -1, 1, 0, 138, 0, 0}; // old pend (10)
        vecs[7]  = '{-1,    0,  -1,  0,  -1, 1, 0, 148, 0, 1}; // boundary sample (20), then udr
        vecs[8]  = '{20,   10, 100, 20,  10, 1, 0, 148, 1, 0}; // overrun, duty held
        vecs[9]  = '{-1,    0,  -1,  0,  10, 1, 0, 148, 0, 1}; // 20 wins, clr drops ovr
        vecs[10] = '{-1,    0,  -1,  0,  -1, 0, 0, 148, 0, 1}; // mute loads midscale
        vecs[11] = '{50, -128,  -1,  0,  -1, 0, 2, 128, 0, 1}; // muted sample discarded
        vecs[12] = '{50, -128,  -1,  0,  -1, 1, 2, 128, 0, 1}; // vol=2 -> 96
        vecs[13] = '{-1,    0,  -1,  0,   5, 1, 0,  96, 0, 1};
        vecs[14] = '{50,  127,  -1,  0,   5, 1, 2,  96, 0, 0}; // 127>>>2 -> 159
        vecs[15] = '{-1,    0,  -1,  0, 255, 1, 0, 159, 0, 1}; // set beats clr

        rst    = 1'b1;
        en     = 1'b1;
        vol    = 2'd0;
        data_i = 8'd0;
        vld_i  = 1'b0;
        clr_i  = 1'b0;
        @(posedge clk);
        #1;
        check("reset pwm_o", int'(pwm_o), 0);
        check("reset tick_o", int'(tick_o), 0);
        check("reset ovr_o", int'(ovr_o), 0);
        check("reset udr_o", int'(udr_o), 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_period(i, vecs[i]);

        // Mid-period reset with an overrun pending and udr set.
        for (int k = 0; k < 100; k++) begin
            vld_i  = (k == 20) || (k == 40);
            data_i = 8'd50;
            @(posedge clk);
            #1;
        end
        vld_i = 1'b0;
        check("pre-reset ovr_o", int'(ovr_o), 1);
        check("pre-reset pwm_o", int'(pwm_o), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid reset pwm_o", int'(pwm_o), 0);
        check("mid reset tick_o", int'(tick_o), 0);
        check("mid reset ovr_o", int'(ovr_o), 0);
        check("mid reset udr_o", int'(udr_o), 0);

        // Counter, duty and started must all be back at reset values.
        idle = '{-1, 0, -1, 0, -1, 1, 0, 128, 0, 0};
        run_period(16, idle);
        run_period(17, idle);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
